// File: rtl/mem_writeback_unit_if.sv
// Bundle of the upstream instruction handshake, the data-memory req/ack bus and the
// register-file writeback port used by mem_writeback_unit.
//   master : the environment side (decode/execute, data memory, register file)
//   slave  : the mem_writeback_unit side
interface mem_writeback_unit_if;
    // Upstream instruction channel
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [31:0] immediate;
    logic [31:0] pc_next;
    logic [4:0]  rd;
    logic        reg_we;
    logic [1:0]  mem_op;
    logic [2:0]  mem_sel;
    logic [1:0]  wb_sel;
    // Data-memory bus
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    // Register-file write port and error pulse
    logic [4:0]  wb_rd;
    logic        wb_reg_we;
    logic [31:0] wb_data;
    logic        mem_err;

    modport master (
        output in_valid, alu_result, rs2_data, immediate, pc_next, rd, reg_we,
               mem_op, mem_sel, wb_sel, dmem_ack, dmem_rdata,
        input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
               wb_rd, wb_reg_we, wb_data, mem_err
    );

    modport slave (
        input  in_valid, alu_result, rs2_data, immediate, pc_next, rd, reg_we,
               mem_op, mem_sel, wb_sel, dmem_ack, dmem_rdata,
        output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
               wb_rd, wb_reg_we, wb_data, mem_err
    );
endinterface

// File: rtl/mem_writeback_unit.sv
// Multi-cycle memory-access and writeback stage.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus_io : instruction handshake in, data-memory req/ack bus out, register-file write
//            port and mem_err pulse out (see mem_writeback_unit_if)
// Non-memory ops write back one cycle after acceptance; loads/stores hold a request until
// ack (or timeout) and write back one cycle after the ack.
module mem_writeback_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_writeback_unit_if.slave  bus_io
);
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StAccess, StWriteback} state_e;

    state_e          state_q;
    logic            req_q, we_q, wb_we_q, err_q;
    logic [31:0]     addr_q, wdata_q, wb_data_q;
    logic [3:0]      wstrb_q;
    logic [4:0]      wb_rd_q, rd_q;
    logic [CntW-1:0] cnt_q;
    // Instruction fields latched for the access and writeback phases
    logic            reg_we_q, is_load_q;
    logic [1:0]      wb_sel_q, off_q;
    logic [2:0]      mem_sel_q;
    logic [31:0]     alt_data_q;  // wb_sel-selected non-load value
    logic [31:0]     ld_data_q;

    logic            accept, is_load, is_store, misaligned;
    logic [3:0]      strb_base;
    logic [31:0]     st_data, sel_val, ld_shift, ld_val;

    always_comb begin
        accept   = bus_io.in_valid && (state_q == StIdle);
        is_load  = (bus_io.mem_op == 2'b01);
        is_store = (bus_io.mem_op == 2'b10);

        // Access size comes from mem_sel[1:0]; the unused 11 encoding is handled as a word.
        unique case (bus_io.mem_sel[1:0])
            2'b00: begin
                misaligned = 1'b0;
                strb_base  = 4'b0001;
                st_data    = {4{bus_io.rs2_data[7:0]}};
            end
            2'b01: begin
                misaligned = bus_io.alu_result[0];
                strb_base  = 4'b0011;
                st_data    = {2{bus_io.rs2_data[15:0]}};
            end
            default: begin
                misaligned = (bus_io.alu_result[1:0] != 2'b00);
                strb_base  = 4'b1111;
                st_data    = bus_io.rs2_data;
            end
        endcase

        unique case (bus_io.wb_sel)
            2'b00:   sel_val = bus_io.alu_result;
            2'b01:   sel_val = ld_data_q;
            2'b10:   sel_val = bus_io.pc_next;
            default: sel_val = bus_io.immediate;
        endcase

        // Halfwords are aligned, so a byte-offset shift serves both sizes.
        ld_shift = bus_io.dmem_rdata >> {off_q, 3'b000};
        unique case (mem_sel_q[1:0])
            2'b00:   ld_val = {{24{~mem_sel_q[2] & ld_shift[7]}}, ld_shift[7:0]};
            2'b01:   ld_val = {{16{~mem_sel_q[2] & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_val = bus_io.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            wb_we_q    <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            cnt_q      <= '0;
            rd_q       <= '0;
            reg_we_q   <= 1'b0;
            is_load_q  <= 1'b0;
            wb_sel_q   <= '0;
            off_q      <= '0;
            mem_sel_q  <= '0;
            alt_data_q <= '0;
            ld_data_q  <= '0;
        end else begin
            wb_we_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (is_load || is_store) begin
                            if (misaligned) begin
                                err_q <= 1'b1;
                            end else begin
                                req_q      <= 1'b1;
                                we_q       <= is_store;
                                addr_q     <= {bus_io.alu_result[31:2], 2'b00};
                                wdata_q    <= is_store ? st_data : '0;
                                wstrb_q    <= is_store ? (strb_base << bus_io.alu_result[1:0])
                                                       : 4'b0000;
                                rd_q       <= bus_io.rd;
                                reg_we_q   <= bus_io.reg_we;
                                is_load_q  <= is_load;
                                wb_sel_q   <= bus_io.wb_sel;
                                mem_sel_q  <= bus_io.mem_sel;
                                off_q      <= bus_io.alu_result[1:0];
                                alt_data_q <= sel_val;
                                cnt_q      <= '0;
                                state_q    <= StAccess;
                            end
                        end else begin
                            wb_we_q   <= bus_io.reg_we && (bus_io.rd != 5'd0);
                            wb_rd_q   <= bus_io.rd;
                            wb_data_q <= sel_val;
                        end
                    end
                end
                StAccess: begin
                    if (bus_io.dmem_ack) begin
                        req_q   <= 1'b0;
                        state_q <= StWriteback;
                        if (is_load_q) begin
                            ld_data_q <= ld_val;
                        end
                    end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWriteback: begin
                    wb_rd_q   <= rd_q;
                    wb_data_q <= (wb_sel_q == 2'b01) ? ld_data_q : alt_data_q;
                    wb_we_q   <= reg_we_q && (rd_q != 5'd0);
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.in_ready   = (state_q == StIdle);
    assign bus_io.dmem_req   = req_q;
    assign bus_io.dmem_we    = we_q;
    assign bus_io.dmem_addr  = addr_q;
    assign bus_io.dmem_wdata = wdata_q;
    assign bus_io.dmem_wstrb = wstrb_q;
    assign bus_io.wb_rd      = wb_rd_q;
    assign bus_io.wb_reg_we  = wb_we_q;
    assign bus_io.wb_data    = wb_data_q;
    assign bus_io.mem_err    = err_q;
endmodule

// File: tb/tb_mem_writeback_unit.sv
// Scoreboard bench for mem_writeback_unit: expected writeback/error pulses are queued as
// instructions and memory responses are driven, and popped when the DUT pulses.
module tb_mem_writeback_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_writeback_unit_if bus ();

    mem_writeback_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    typedef struct packed {
        logic        err;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Pending memory instruction, kept for the memory responder
    logic [31:0] p_alu, p_rs2, p_other;
    logic [4:0]  p_rd;
    logic        p_we;
    logic [1:0]  p_op, p_wsel;
    logic [2:0]  p_sel;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] ld_model(input logic [2:0] sel, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (sel)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    task automatic push_exp(input logic err, input logic [4:0] rd, input logic [31:0] data);
        exp_t t;
        t.err  = err;
        t.rd   = rd;
        t.data = data;
        sb_q.push_back(t);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [2:0] sel, input logic [1:0] wsel,
                         input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic we);
        int   n = 0;
        logic mis;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_issue", bus.in_ready, 1);
        bus.in_valid   = 1'b1;
        bus.alu_result = alu;
        bus.rs2_data   = rs2;
        bus.immediate  = ~alu;
        bus.pc_next    = alu + 32'h1000;
        bus.rd         = rd;
        bus.reg_we     = we;
        bus.mem_op     = op;
        bus.mem_sel    = sel;
        bus.wb_sel     = wsel;
        p_alu = alu; p_rs2 = rs2; p_rd = rd; p_we = we; p_op = op; p_sel = sel; p_wsel = wsel;
        p_other = (wsel == 2'd2) ? alu + 32'h1000 : (wsel == 2'd3) ? ~alu : alu;
        mis = ((sel[1:0] == 2'b01) && alu[0]) || ((sel[1:0] >= 2'b10) && (alu[1:0] != 2'b00));
        if (op == 2'b01 || op == 2'b10) begin
            if (mis) push_exp(1'b1, 5'd0, 32'd0);
        end else if (we && rd != 5'd0) begin
            push_exp(1'b0, rd, p_other);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Memory responder: request must stay stable for nwait cycles, then ack.
    task automatic serve(input int nwait, input logic [31:0] rdata);
        logic [3:0]  strb;
        logic [31:0] wd;
        case (p_sel[1:0])
            2'b00:   begin strb = 4'b0001 << p_alu[1:0]; wd = {4{p_rs2[7:0]}}; end
            2'b01:   begin strb = 4'b0011 << p_alu[1:0]; wd = {2{p_rs2[15:0]}}; end
            default: begin strb = 4'b1111; wd = p_rs2; end
        endcase
        for (int i = 0; i <= nwait; i++) begin
            check("req_held", bus.dmem_req, 1);
            check("addr", bus.dmem_addr, {p_alu[31:2], 2'b00});
            check("we", bus.dmem_we, p_op == 2'b10);
            check("wstrb", bus.dmem_wstrb, (p_op == 2'b10) ? strb : 4'b0000);
            if (p_op == 2'b10) check("wdata", bus.dmem_wdata, wd);
            if (i == nwait) begin
                bus.dmem_ack   = 1'b1;
                bus.dmem_rdata = rdata;
                if (p_we && p_rd != 5'd0)
                    push_exp(1'b0, p_rd,
                             (p_wsel == 2'b01) ? ld_model(p_sel, p_alu[1:0], rdata) : p_other);
            end
            @(negedge clk);
        end
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = $urandom;
        check("req_dropped", bus.dmem_req, 0);
        check("wb_stall", bus.in_ready, 0);
    endtask

    always @(negedge clk) begin
        if (bus.wb_reg_we || bus.mem_err) begin
            check("sb_pending", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("sb_err", bus.mem_err, mon_e.err);
                check("sb_we", bus.wb_reg_we, !mon_e.err);
                if (!mon_e.err) begin
                    check("sb_rd", bus.wb_rd, mon_e.rd);
                    check("sb_data", bus.wb_data, mon_e.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  lsels [5];
        logic [31:0] a, w;
        logic [2:0]  s;
        int          n;
        lsels = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.alu_result = '0; bus.rs2_data = '0; bus.immediate = '0;
        bus.pc_next = '0; bus.rd = '0; bus.reg_we = 1'b0; bus.mem_op = '0; bus.mem_sel = '0;
        bus.wb_sel = '0; bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_req", bus.dmem_req, 0);
        check("rst_we", bus.dmem_we, 0);
        check("rst_addr", bus.dmem_addr, 0);
        check("rst_wdata", bus.dmem_wdata, 0);
        check("rst_wstrb", bus.dmem_wstrb, 0);
        check("rst_wb_we", bus.wb_reg_we, 0);
        check("rst_wb_rd", bus.wb_rd, 0);
        check("rst_wb_data", bus.wb_data, 0);
        check("rst_err", bus.mem_err, 0);
        check("rst_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD-style op
        issue(2'b00, 3'b000, 2'b00, 32'h0000_1234, 32'd0, 5'd5, 1'b1);
        check("add_ready", bus.in_ready, 1);
        check("add_data", bus.wb_data, 32'h0000_1234);
        // LUI and JAL selects
        issue(2'b11, 3'b000, 2'b11, 32'h0000_5000, 32'd0, 5'd6, 1'b1);
        issue(2'b00, 3'b000, 2'b10, 32'h0000_0040, 32'd0, 5'd1, 1'b1);

        // LB / LBU at 0x103 with one wait cycle (request held two cycles)
        issue(2'b01, 3'b000, 2'b01, 32'h0000_0103, 32'd0, 5'd7, 1'b1);
        serve(1, 32'h80AB_CDEF);
        @(negedge clk);
        check("lb_data", bus.wb_data, 32'hFFFF_FF80);
        issue(2'b01, 3'b100, 2'b01, 32'h0000_0103, 32'd0, 5'd8, 1'b1);
        serve(1, 32'h80AB_CDEF);
        @(negedge clk);
        check("lbu_data", bus.wb_data, 32'h0000_0080);

        // SH at 0x202
        issue(2'b10, 3'b001, 2'b00, 32'h0000_0202, 32'h1234_BEEF, 5'd0, 1'b0);
        check("sh_wstrb", bus.dmem_wstrb, 4'b1100);
        check("sh_wdata", bus.dmem_wdata, 32'hBEEF_BEEF);
        serve(0, 32'd0);
        @(negedge clk);

        // Misaligned LW, then JAL to x0
        issue(2'b01, 3'b010, 2'b01, 32'h0000_0101, 32'd0, 5'd9, 1'b1);
        check("lw_mis_noreq", bus.dmem_req, 0);
        check("lw_mis_ready", bus.in_ready, 1);
        issue(2'b00, 3'b000, 2'b10, 32'h0000_0080, 32'd0, 5'd0, 1'b1);
        check("jal_x0_we", bus.wb_reg_we, 0);

        // Random aligned loads and stores
        for (int k = 0; k < 12; k++) begin
            a = $urandom;
            w = $urandom;
            if ($urandom_range(1)) begin
                s = lsels[$urandom_range(4)];
                if (s[1:0] == 2'b01) a[0] = 1'b0;
                if (s[1:0] == 2'b10) a[1:0] = 2'b00;
                issue(2'b01, s, 2'b01, a, 32'd0, 5'($urandom_range(31)), 1'b1);
            end else begin
                s = 3'($urandom_range(2));
                if (s[1:0] == 2'b01) a[0] = 1'b0;
                if (s[1:0] == 2'b10) a[1:0] = 2'b00;
                issue(2'b10, s, 2'b00, a, $urandom, 5'($urandom_range(31)), 1'b0);
            end
            serve($urandom_range(3), w);
        end

        // Timeout: no ack ever
        issue(2'b01, 3'b010, 2'b01, 32'h0000_0400, 32'd0, 5'd10, 1'b1);
        push_exp(1'b1, 5'd0, 32'd0);
        n = 0;
        while (bus.dmem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("timeout_req_cycles", n, 16);
        check("timeout_ready", bus.in_ready, 1);

        // Reset during ACCESS; a late ack must not write back
        issue(2'b01, 3'b010, 2'b01, 32'h0000_0800, 32'd0, 5'd11, 1'b1);
        check("rst_access_req", bus.dmem_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_req", bus.dmem_req, 0);
        check("rst_mid_ready", bus.in_ready, 1);
        check("rst_mid_addr", bus.dmem_addr, 0);
        rst_n = 1'b1;
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("late_ack_no_req", bus.dmem_req, 0);
        issue(2'b00, 3'b000, 2'b00, 32'h0000_0777, 32'd0, 5'd12, 1'b1);

        repeat (4) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_writeback_unit.md
Name: mem_writeback_unit

Overview:
- Multi-cycle memory-access and writeback stage.
- Consumes the decoded control and operands produced by instruction decode and execute.
- Performs loads and stores over a req/ack data-memory handshake.
- Drives the register-file write port wb_rd / wb_reg_we / wb_data back into instruction decode.
- Stalls upstream via in_ready while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles to wait for dmem_ack before aborting the access with an error.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  unit can accept an instruction this cycle
- alu_result  input  32  ALU result; serves as the memory address for loads and stores
- rs2_data  input  32  store data
- immediate  input  32  immediate, selected for LUI writeback
- pc_next  input  32  pc+4, selected for JAL/JALR writeback
- rd  input  5  destination register
- reg_we  input  1  register write enable from decode
- mem_op  input  2  00 none, 01 load, 10 store, 11 treated as none
- mem_sel  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use bits [1:0] only
- wb_sel  input  2  00 alu_result, 01 load data, 10 pc_next, 11 immediate
- dmem_req  output  1  memory request, held until ack
- dmem_we  output  1  1 = store
- dmem_addr  output  32  word-aligned address ({alu_result[31:2],2'b00})
- dmem_wdata  output  32  store data shifted into byte lanes
- dmem_wstrb  output  4  byte-lane strobes; 0000 for loads
- dmem_ack  input  1  memory completion; read data valid in the same cycle
- dmem_rdata  input  32  read word
- wb_rd  output  5  register-file write address
- wb_reg_we  output  1  register-file write enable, one-cycle pulse
- wb_data  output  32  register-file write data
- mem_err  output  1  one-cycle pulse on misalignment or timeout

Behaviour:
- Reset (rst_n low at a rising clk edge): state IDLE; dmem_req, dmem_we, wb_reg_we, mem_err = 0; dmem_addr, dmem_wdata, wb_data = 0; dmem_wstrb = 0; wb_rd = 0; timeout counter = 0. Reset mid-access drops dmem_req at that edge; a late ack is then ignored.
- in_ready = 1 only in state IDLE. An instruction is accepted on a cycle where in_valid && in_ready.
- FSM states: IDLE, ACCESS, WRITEBACK.
- IDLE, accept with mem_op none (00 or 11):
  - Next cycle: wb_reg_we = reg_we && (rd != 0); wb_rd = rd; wb_data per wb_sel.
  - Latency 1; state remains IDLE, so back-to-back acceptance is possible.
- IDLE, accept with load or store, alignment check:
  - Misaligned: halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - On misalignment: no request; next cycle mem_err = 1, wb_reg_we = 0; state remains IDLE.
- IDLE, accept with aligned load or store:
  - Register dmem_req = 1 with dmem_addr, dmem_we, dmem_wdata, dmem_wstrb; go to ACCESS.
  - Latch rd, reg_we, wb_sel, mem_sel and addr[1:0].
- Store lanes:
  - SB: wstrb = 0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: wstrb = 0011 << addr[1:0]; wdata = {2{rs2[15:0]}}.
  - SW: wstrb = 1111; wdata = rs2.
- ACCESS:
  - dmem_req and all request outputs stay stable until dmem_ack is sampled high.
  - Ack is accepted in the first ACCESS cycle (zero-wait memory allowed).
  - On ack: drop dmem_req; for loads, extract the byte/halfword at the latched addr[1:0], then sign- or zero-extend per mem_sel; capture the result; go to WRITEBACK.
  - Counter increments each ACCESS cycle without ack. On reaching TIMEOUT_CYCLES: drop dmem_req, pulse mem_err, no register write, return to IDLE.
- WRITEBACK (one cycle):
  - wb_rd = latched rd; wb_data per latched wb_sel (01 selects captured load data).
  - wb_reg_we = latched reg_we && (rd != 0). Stores have reg_we = 0, so no write.
  - Next state IDLE. in_ready = 0 during WRITEBACK, giving a memory-op latency of ack + 1 cycles.
- Outputs in cycles without a writeback:
  - wb_reg_we and mem_err = 0 outside their pulse cycles.
  - wb_data and wb_rd hold their last values.
- Protocol rules:
  - dmem_ack while dmem_req = 0 is ignored.
  - in_valid while in_ready = 0 is ignored; upstream must hold its instruction.

Test Plan:
- ADD-style op: alu_result = 0x0000_1234, rd = 5, reg_we = 1, wb_sel = 00 -> next cycle wb_reg_we = 1, wb_rd = 5, wb_data = 0x0000_1234; in_ready stays 1.
- LB at addr 0x103, memory returns 0x80AB_CDEF with 2-cycle ack delay -> dmem_req held 2 cycles at dmem_addr 0x100, wstrb = 0000; WRITEBACK wb_data = 0xFFFF_FF80; LBU gives 0x0000_0080.
- SH at addr 0x202, rs2 = 0x1234_BEEF -> dmem_we = 1, wstrb = 1100, wdata = 0xBEEF_BEEF; wb_reg_we stays 0.
- LW at addr 0x101 -> no dmem_req, mem_err pulses 1 cycle, wb_reg_we = 0; JAL with rd = 0, wb_sel = 10 -> wb_reg_we = 0.
- Load with ack never asserted -> dmem_req drops after 16 cycles, mem_err pulses, in_ready returns to 1.
- rst_n low during ACCESS -> next edge dmem_req = 0, state IDLE; a following ack produces no writeback.
